imem_dmem_arbiter: RTL

Shares one single-port unified memory between the instruction fetch stage (IF port) and the memory stage (MEM port), replacing the private instruction ROM and data RAM with a single memory behind a variable-latency handshake. A three-state FSM grants one requester at a time, holds the memory interface stable until the memory signals completion, and then returns registered read data with a one-cycle ready pulse. MEM has priority, and a starvation counter guarantees IF forward progress. The pipeline uses `if_ready` and `mem_ready` to drive its freeze/stall logic.

---
 rtl/imem_dmem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/imem_dmem_arbiter.sv
// Arbiter that time-shares one single-port unified memory between instruction fetch
// and the memory stage, with MEM priority bounded by a starvation counter for IF.
module imem_dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t     state, state_next;
  logic [3:0] starve_cnt, starve_next;
  logic       if_eff, mem_eff;
  logic       grant_if, grant_mem;
  logic       done_if, done_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // A requester whose ready pulse is showing is still holding its old request, so mask it
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    grant_if    = 1'b0;
    grant_mem   = 1'b0;
    done_if     = 1'b0;
    done_mem    = 1'b0;
    if_eff      = if_req & ~if_ready;
    mem_eff     = (mem_rd_req | mem_wr_req) & ~mem_ready;
    case (state)
      IDLE: begin
        if (mem_eff && (!if_eff || (starve_cnt < MAX_WAIT_C))) begin
          grant_mem  = 1'b1;
          state_next = SERVE_MEM;
          if (if_eff) begin
            starve_next = starve_cnt + 4'd1;
          end
        end else if (if_eff) begin
          grant_if    = 1'b1;
          state_next  = SERVE_IF;
          starve_next = 4'd0;
        end
      end
      SERVE_IF: begin
        if (ram_done) begin
          done_if    = 1'b1;
          state_next = IDLE;
        end
      end
      SERVE_MEM: begin
        if (ram_done) begin
          done_mem   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side request is latched at grant and held until completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      if (grant_mem) begin
        ram_addr  <= mem_addr;
        ram_we    <= mem_wr_req;
        ram_wdata <= mem_wdata;
      end else if (grant_if) begin
        ram_addr <= if_addr;
        ram_we   <= 1'b0;
      end else if (done_if || done_mem) begin
        ram_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ready  <= done_if;
      mem_ready <= done_mem;
      if (done_if) begin
        if_rdata <= ram_rdata;
      end
      if (done_mem && !ram_we) begin
        mem_rdata <= ram_rdata;
      end
    end
  end

  assign ram_en = (state != IDLE);

endmodule
